// File: rtl/reg_pkg.sv
// reg_pkg: funsel encodings and select-width helper shared by register-file style blocks.
package reg_pkg;
   localparam logic [1:0] FS_CLR  = 2'b00;
   localparam logic [1:0] FS_LOAD = 2'b01;
   localparam logic [1:0] FS_DEC  = 2'b10;
   localparam logic [1:0] FS_INC  = 2'b11;
   function automatic int sel_bits(input int n);
      int b;
      b = 0;
      while ((1 << b) < n) b++;
      return b;
   endfunction
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one register with clear/load/dec/inc, wrap or saturate, and a sticky overflow flag.
module reg_cell
   import reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SATURATE = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_load,
   input  logic [1:0]       i_funsel,
   input  logic             i_en,
   input  logic             i_ovf_clr,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_nxt,
   output logic             o_zero,
   output logic             o_ovf
);
   logic [WIDTH-1:0] r_q, w_calc;
   logic r_ovf, w_max, w_min, w_bound;
   always_comb begin
      w_max = &r_q;
      w_min = r_q == '0;
      w_bound = i_en && ((i_funsel == FS_INC && w_max) || (i_funsel == FS_DEC && w_min));
      w_calc = i_funsel == FS_CLR  ? '0 :
               i_funsel == FS_LOAD ? i_load :
               i_funsel == FS_DEC  ? ((SATURATE != 0 && w_min) ? r_q : r_q - WIDTH'(1)) :
                                     ((SATURATE != 0 && w_max) ? r_q : r_q + WIDTH'(1));
      o_nxt = rst ? RESET_VAL : i_en ? w_calc : r_q;
   end
   // a boundary hit in the same cycle as a clear request keeps the flag set
   always_ff @(posedge clk) begin
      r_q <= o_nxt;
      r_ovf <= rst ? 1'b0 : (w_bound || (r_ovf && !i_ovf_clr));
   end
   assign o_q = r_q;
   assign o_zero = r_q == '0;
   assign o_ovf = r_ovf;
endmodule

// File: rtl/reg_file_gen.sv
// reg_file_gen: NREGS x WIDTH register file with shared funsel, multi-hot write select,
// zero/overflow flags and two combinational read ports with optional write bypass.
module reg_file_gen
   import reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 8,
   parameter int SELW = 3,
   parameter int SATURATE = 0,
   parameter int BYPASS = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load,
   input  logic [1:0]       funsel,
   input  logic [NREGS-1:0] rsel,
   input  logic [SELW-1:0]  o1sel,
   input  logic [SELW-1:0]  o2sel,
   input  logic [NREGS-1:0] ovf_clr,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [NREGS-1:0] zero,
   output logic [NREGS-1:0] ovf
);
   logic [WIDTH-1:0] w_q [NREGS];
   logic [WIDTH-1:0] w_nxt [NREGS];
   if (SELW < sel_bits(NREGS) || NREGS < 2 || NREGS > 16) begin : g_param_err
      $error("reg_file_gen: NREGS must be 2..16 and 2**SELW >= NREGS");
   end
   for (genvar g = 0; g < NREGS; g++) begin : g_cell
      reg_cell #(
         .WIDTH(WIDTH),
         .SATURATE(SATURATE),
         .RESET_VAL(RESET_VAL)
      ) u_cell (
         .clk(clk),
         .rst(rst),
         .i_load(load),
         .i_funsel(funsel),
         .i_en(rsel[g]),
         .i_ovf_clr(ovf_clr[g]),
         .o_q(w_q[g]),
         .o_nxt(w_nxt[g]),
         .o_zero(zero[g]),
         .o_ovf(ovf[g])
      );
   end
   // selects with no matching register fall through to zero
   always_comb begin
      o1 = '0;
      o2 = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (o1sel == SELW'(i)) o1 = (BYPASS != 0 && (rsel[i] || rst)) ? w_nxt[i] : w_q[i];
         if (o2sel == SELW'(i)) o2 = (BYPASS != 0 && (rsel[i] || rst)) ? w_nxt[i] : w_q[i];
      end
   end
endmodule
